spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Synthesizable SPI master that drives sck/csn/mosi and samples miso. It is the initiator counterpart to the bench SPI slave model. It supports all four CPOL/CPHA modes at runtime, 1..32-bit MSB-first frames and a programmable sck divider. The host side uses a start/busy/done handshake, and the block sits between a CPU/bench register interface and the SPI pins.

Parameters:
DIV_W, 8, width of clk_div (half-period divider)
MAX_BITS, 32, maximum frame length; tx_data/rx_data width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request a frame; accepted only when busy==0
mode  input  2  {cpol,cpha}; latched on accepted start
nbits  input  6  frame length; 0 or >32 means 32
clk_div  input  DIV_W  sck half-period = clk_div+1 clk cycles; latched on start
tx_data  input  MAX_BITS  frame to send, right-aligned; bit nbits-1 goes first
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse when the frame is complete
rx_data  output  MAX_BITS  received frame, right-aligned, upper bits zero
sck  output  1  SPI clock
csn  output  1  chip select, active-low
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset values: busy=0, done=0, rx_data=0, csn=1, mosi=0, state=IDLE. sck=0 in the reset cycle; in IDLE, sck<=mode[1] every cycle.
- Notation: H=clk_div+1. T is the cycle in which start is sampled high with busy==0.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE: on start, latch mode, nbits, clk_div and tx_data into shift register; go to SETUP. csn falls at T+1; busy=1 from T+1.
- SETUP: lasts H cycles.
  - CPHA=0: mosi = tx[n-1] from T+1.
  - CPHA=1: mosi is held.
- XFER: 2n sck edges, where n is the effective nbits. Edge k (k=1..2n) occurs at T+1+k*H. Odd k is the leading edge; even k is the trailing edge.
  - CPHA=0: sample miso on leading edges. Shift mosi on trailing edges except edge 2n.
  - CPHA=1: drive the next mosi bit on leading edges. Sample miso on trailing edges.
  - The sample register shifts left with miso entering the LSB. Sampling uses the clk cycle of the edge, i.e. the value present before the sck register updates.
- HOLD: after edge 2n, sck sits at CPOL; csn rises at T+1+(2n+1)*H.
- GAP: csn stays high for H cycles. The done pulse and busy fall occur together at T+1+(2n+2)*H. rx_data updates in the same cycle.
- start while busy: ignored, with no effect on the current frame. start in the done cycle is accepted (back-to-back frames).
- Input changes while busy (mode, nbits, clk_div, tx_data): no effect.
- Half-period counter: counts 0..clk_div and wraps. It reloads on every state change; with clk_div=0, sck toggles every cycle.
- rst mid-frame: next cycle csn=1, busy=0, no done pulse, rx_data keeps its last completed value.

Decomposition:
- Package spi_pkg: state enum (IDLE, SETUP, XFER, HOLD, GAP), MODE0..MODE3 constants, MAX_BITS, and an nbits-normalise function (0/>32 -> 32).
- One sub-module, spi_half_tick: the DIV_W counter with load/enable, emitting a tick on the terminal count.

Test Plan:
- Mode 0, nbits=8, clk_div=1, tx=0xA5, slave returns 0x3C:
  - mosi at leading edges = 1,0,1,0,0,1,0,1.
  - rx_data=0x3C.
  - done at T+37; csn low T+1..T+34.
- Mode 3, nbits=8, clk_div=0, tx=0x81, slave returns 0xF0:
  - sck idle high.
  - rx=0xF0, mosi changes only on falling edges.
  - done at T+19.
- Mode 1 and mode 2, nbits=32, tx=0xDEADBEEF, loopback miso=mosi -> rx_data=0xDEADBEEF in both modes.
- nbits=0 -> 32-bit frame; nbits=1, tx=0x1 -> exactly 2 sck edges, rx_data bits [31:1]=0.
- start asserted during busy and again in the done cycle -> first ignored, second begins a new frame with csn falling the next cycle.
- rst asserted at edge 5 of an 8-bit frame -> next cycle csn=1, busy=0, sck=0, no done, rx_data unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master controller.
//   - spi_state_e : controller phases (IDLE, SETUP, XFER, HOLD, GAP)
//   - MODE0..MODE3: {cpol,cpha} encodings
//   - MAX_BITS    : longest supported frame
//   - norm_nbits  : maps a requested frame length onto 1..MAX_BITS
package spi_pkg;

    localparam int MAX_BITS = 32;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_e;

    // A length of zero, or anything beyond the shifter width, means a full-width frame.
    function automatic logic [5:0] norm_nbits(input logic [5:0] nbits);
        if (nbits == 6'd0 || nbits > 6'(MAX_BITS)) begin
            return 6'(MAX_BITS);
        end
        return nbits;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host-side handshake bundle of the SPI master.
//   master modport (host/CPU side): drives start, mode, nbits, clk_div, tx_data;
//                                   observes busy, done, rx_data.
//   slave modport  (controller)   : the reverse.
interface spi_master_ctrl_if #(
    parameter int DIV_W    = 8,
    parameter int MAX_BITS = spi_pkg::MAX_BITS
) ();

    logic                start;
    logic [1:0]          mode;
    logic [5:0]          nbits;
    logic [DIV_W-1:0]    clk_div;
    logic [MAX_BITS-1:0] tx_data;
    logic                busy;
    logic                done;
    logic [MAX_BITS-1:0] rx_data;

    modport master (
        output start, mode, nbits, clk_div, tx_data,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, mode, nbits, clk_div, tx_data,
        output busy, done, rx_data
    );

endinterface

// File: rtl/spi_half_tick.sv
// spi_half_tick: sck half-period timer.
//   clk, rst : system clock, synchronous active-high reset
//   load     : force the count back to zero (held while the controller is idle)
//   en       : count enable
//   div      : terminal count; the period is div+1 cycles
//   tick     : high in the cycle the count sits at its terminal value
module spi_half_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Wrapping on the tick means every phase change (which only happens on a
    // tick or out of idle) starts the next phase with a fresh count.
    always_comb begin
        tick  = en && !load && (cnt_q == div);
        cnt_d = cnt_q;
        if (load || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master, all four CPOL/CPHA modes, 1..32-bit MSB-first frames.
//   clk, rst : system clock, synchronous active-high reset
//   host     : spi_master_ctrl_if.slave -- start/mode/nbits/clk_div/tx_data in,
//              busy/done/rx_data out
//   sck      : SPI clock, idles at CPOL
//   csn      : chip select, active-low
//   mosi     : serial data out, MSB first
//   miso     : serial data in
module spi_master_ctrl #(
    parameter int DIV_W    = 8,
    parameter int MAX_BITS = spi_pkg::MAX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.slave    host,
    output logic                sck,
    output logic                csn,
    output logic                mosi,
    input  logic                miso
);

    import spi_pkg::*;

    spi_state_e          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                csn_q, csn_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                cpha_q, cpha_d;
    logic [5:0]          nbits_q, nbits_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [MAX_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [MAX_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [MAX_BITS-1:0] rx_data_q, rx_data_d;
    logic [6:0]          edge_q, edge_d;

    logic [5:0]          nb_norm;
    logic [6:0]          shamt;
    logic [MAX_BITS-1:0] tx_aligned;
    logic [6:0]          edge_next;
    logic                lead_edge;
    logic                last_edge;
    logic                tick;

    spi_half_tick #(.DIV_W(DIV_W)) u_half_tick (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == IDLE),
        .en   (busy_q),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        csn_d     = csn_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cpha_d    = cpha_q;
        nbits_d   = nbits_q;
        div_d     = div_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;

        // The frame is left-aligned in the shifter so the next bit out is always the MSB.
        nb_norm    = norm_nbits(host.nbits);
        shamt      = 7'(MAX_BITS) - {1'b0, nb_norm};
        tx_aligned = host.tx_data << shamt;

        // Odd-numbered sck edges leave the idle level, even ones return to it.
        edge_next = edge_q + 7'd1;
        lead_edge = edge_next[0];
        last_edge = (edge_next == {nbits_q, 1'b0});

        unique case (state_q)
            IDLE: begin
                sck_d = (host.mode == MODE2) || (host.mode == MODE3);
                if (host.start) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    cpha_d  = (host.mode == MODE1) || (host.mode == MODE3);
                    nbits_d = nb_norm;
                    div_d   = host.clk_div;
                    rx_sh_d = '0;
                    edge_d  = '0;
                    // CPHA=0 must present the first bit before the first edge;
                    // CPHA=1 leaves mosi alone until the first leading edge.
                    if (host.mode[0]) begin
                        tx_sh_d = tx_aligned;
                    end else begin
                        mosi_d  = tx_aligned[MAX_BITS-1];
                        tx_sh_d = tx_aligned << 1;
                    end
                end
            end
            SETUP, XFER: begin
                if (tick) begin
                    edge_d  = edge_next;
                    sck_d   = ~sck_q;
                    state_d = last_edge ? HOLD : XFER;
                    // miso is taken in the edge cycle, before sck actually moves.
                    if (lead_edge) begin
                        if (!cpha_q) begin
                            rx_sh_d = {rx_sh_q[MAX_BITS-2:0], miso};
                        end else begin
                            mosi_d  = tx_sh_q[MAX_BITS-1];
                            tx_sh_d = tx_sh_q << 1;
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_sh_d = {rx_sh_q[MAX_BITS-2:0], miso};
                        end else if (!last_edge) begin
                            mosi_d  = tx_sh_q[MAX_BITS-1];
                            tx_sh_d = tx_sh_q << 1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    csn_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset that cuts a frame short keeps the last completed rx_data;
    // a reset while idle (including power-up) clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cpha_q  <= 1'b0;
            nbits_q <= '0;
            div_q   <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            edge_q  <= '0;
            if (!busy_q) begin
                rx_data_q <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            csn_q     <= csn_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cpha_q    <= cpha_d;
            nbits_q   <= nbits_d;
            div_q     <= div_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
        end
    end

    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.rx_data = rx_data_q;
    assign sck          = sck_q;
    assign csn          = csn_q;
    assign mosi         = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed and randomized frames against a behavioural SPI
// slave plus frame-timing arithmetic; rx_data, mosi bit order, edge counts,
// csn/done timing, reset and back-to-back behaviour are compared.
module tb_spi_master_ctrl;

    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck, csn, mosi, miso;

    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DIV_W(8), .MAX_BITS(32)) host_if ();

    spi_master_ctrl #(.DIV_W(8), .MAX_BITS(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (host_if),
        .sck  (sck),
        .csn  (csn),
        .mosi (mosi),
        .miso (miso)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame context shared with the slave model
    bit          cur_cpol = 1'b0;
    bit          cur_cpha = 1'b0;
    int          cur_n    = 8;
    logic [31:0] slave_tx = '0;
    bit          loopback = 1'b0;
    logic        s_miso   = 1'b0;
    logic [31:0] last_rx  = '0;

    // Observations gathered by the monitor
    logic [31:0] s_in         = '0;
    int          s_ptr        = 0;
    int          edges        = 0;
    int          mosi_bad     = 0;
    int          csn_fall_cyc = 0;
    int          csn_rise_cyc = 0;
    logic        csn_prev     = 1'b1;
    logic        sck_prev     = 1'b0;
    logic        mosi_prev    = 1'b0;

    assign miso = loopback ? mosi : s_miso;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI slave plus pin monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (csn_prev && !csn) begin
            edges        = 0;
            mosi_bad     = 0;
            csn_fall_cyc = cyc;
            s_in         = '0;
            s_ptr        = cur_n;
            if (!cur_cpha) begin
                s_ptr  = s_ptr - 1;
                s_miso = slave_tx[s_ptr];
            end
        end else if (!csn) begin
            if (sck != sck_prev) begin
                edges++;
                if ((sck_prev == cur_cpol) != cur_cpha) begin
                    s_in = {s_in[30:0], mosi};
                end else if (s_ptr > 0) begin
                    s_ptr  = s_ptr - 1;
                    s_miso = slave_tx[s_ptr];
                end
            end
            if (mosi != mosi_prev &&
                !(sck != sck_prev && sck == (cur_cpha ? !cur_cpol : cur_cpol))) begin
                mosi_bad++;
            end
        end
        if (!csn_prev && csn) csn_rise_cyc = cyc;
        csn_prev  = csn;
        sck_prev  = sck;
        mosi_prev = mosi;
    end

    function automatic int effBits(input int nb);
        return (nb == 0 || nb > 32) ? 32 : nb;
    endfunction

    function automatic logic [31:0] lowMask(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic startFrame(input logic [1:0] m, input int nb, input int div,
                              input logic [31:0] tx, input logic [31:0] stx,
                              input bit lb, input string tag, output int t0);
        cur_cpol         = m[1];
        cur_cpha         = m[0];
        cur_n            = effBits(nb);
        slave_tx         = stx;
        loopback         = lb;
        host_if.mode     = m;
        host_if.nbits    = 6'(nb);
        host_if.clk_div  = 8'(div);
        host_if.tx_data  = tx;
        host_if.start    = 1'b1;
        t0 = cyc;
        @(negedge clk);
        host_if.start = 1'b0;
        checkOutput({tag, "_csn_fall"}, csn, 1'b0);
        checkOutput({tag, "_busy_rise"}, host_if.busy, 1'b1);
        checkOutput({tag, "_sck_setup"}, sck, m[1]);
    endtask

    // Returns at the negedge of the done cycle; inputs are scrambled while busy.
    task automatic finishFrame(input int t0, input int n, input int div,
                               input logic [31:0] exp_rx, input logic [31:0] exp_mosi,
                               input string tag);
        int h         = div + 1;
        int idle_busy = 0;
        bit got       = 1'b0;
        int done_cyc  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (host_if.done === 1'b1) begin
                got      = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (host_if.busy !== 1'b1) idle_busy++;
            host_if.mode    = 2'($urandom);
            host_if.nbits   = 6'($urandom);
            host_if.clk_div = 8'($urandom);
            host_if.tx_data = $urandom;
            @(negedge clk);
        end
        host_if.mode = {cur_cpol, cur_cpha};
        if (!got) begin
            checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
            return;
        end
        checkOutput({tag, "_done_cycle"}, 64'(done_cyc - t0), 64'(1 + (2 * n + 2) * h));
        checkOutput({tag, "_busy_held"}, 64'(idle_busy), 64'd0);
        checkOutput({tag, "_busy_fall"}, host_if.busy, 1'b0);
        checkOutput({tag, "_rx_data"}, host_if.rx_data, exp_rx);
        checkOutput({tag, "_mosi_bits"}, s_in, exp_mosi);
        checkOutput({tag, "_edges"}, 64'(edges), 64'(2 * n));
        checkOutput({tag, "_csn_fall_cycle"}, 64'(csn_fall_cyc - t0), 64'd1);
        checkOutput({tag, "_csn_rise_cycle"}, 64'(csn_rise_cyc - t0), 64'(1 + (2 * n + 1) * h));
        checkOutput({tag, "_mosi_change_edge"}, 64'(mosi_bad), 64'd0);
        checkOutput({tag, "_sck_idle"}, sck, cur_cpol);
        last_rx = exp_rx;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input int nb, input int div,
                                 input logic [31:0] tx, input logic [31:0] stx,
                                 input bit lb, input string tag);
        int          t0;
        int          n;
        logic [31:0] exp_tx;
        logic [31:0] exp_rx;
        n      = effBits(nb);
        exp_tx = tx & lowMask(n);
        exp_rx = lb ? exp_tx : (stx & lowMask(n));
        @(negedge clk);
        startFrame(m, nb, div, tx, stx, lb, tag, t0);
        finishFrame(t0, n, div, exp_rx, exp_tx, tag);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, host_if.done, 1'b0);
    endtask

    initial begin
        int          t0;
        int          t1;
        int          done_seen;
        logic [31:0] rtx;
        logic [31:0] rstx;

        host_if.start   = 1'b0;
        host_if.mode    = MODE0;
        host_if.nbits   = 6'd8;
        host_if.clk_div = 8'd1;
        host_if.tx_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", host_if.busy, 1'b0);
        checkOutput("rst_done", host_if.done, 1'b0);
        checkOutput("rst_rx", host_if.rx_data, 32'h0);
        checkOutput("rst_csn", csn, 1'b1);
        checkOutput("rst_mosi", mosi, 1'b0);
        checkOutput("rst_sck", sck, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] directed frames");
        applyStimulus(MODE0, 8, 1, 32'hA5, 32'h3C, 1'b0, "m0_a5");
        applyStimulus(MODE3, 8, 0, 32'h81, 32'hF0, 1'b0, "m3_81");
        applyStimulus(MODE1, 32, 2, 32'hDEADBEEF, 32'h0, 1'b1, "m1_loop");
        applyStimulus(MODE2, 32, 1, 32'hDEADBEEF, 32'h0, 1'b1, "m2_loop");
        applyStimulus(MODE0, 0, 1, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, "n0_full");
        applyStimulus(MODE1, 1, 1, 32'h1, 32'hFFFF_FFFF, 1'b0, "n1");
        checkOutput("n1_upper_zero", host_if.rx_data >> 1, 32'h0);

        $display("[TB] start while busy, then back-to-back");
        @(negedge clk);
        startFrame(MODE0, 8, 1, 32'h5A, 32'h99, 1'b0, "b2b_a", t0);
        repeat (4) @(negedge clk);
        host_if.start   = 1'b1;
        host_if.nbits   = 6'd3;
        host_if.tx_data = 32'hFFFF_FFFF;
        @(negedge clk);
        host_if.start = 1'b0;
        finishFrame(t0, 8, 1, 32'h99, 32'h5A, "b2b_a");
        startFrame(MODE2, 12, 0, 32'h0000_0C3A, 32'h0000_0A5F, 1'b0, "b2b_b", t1);
        finishFrame(t1, 12, 0, 32'h0000_0A5F, 32'h0000_0C3A, "b2b_b");
        @(negedge clk);
        checkOutput("b2b_b_done_pulse", host_if.done, 1'b0);

        $display("[TB] reset mid-frame");
        @(negedge clk);
        startFrame(MODE0, 8, 1, 32'h6B, 32'h2D, 1'b0, "rst_mid", t0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_csn", csn, 1'b1);
        checkOutput("rst_mid_busy", host_if.busy, 1'b0);
        checkOutput("rst_mid_sck", sck, 1'b0);
        checkOutput("rst_mid_done", host_if.done, 1'b0);
        checkOutput("rst_mid_rx_kept", host_if.rx_data, last_rx);
        done_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (host_if.done === 1'b1) done_seen++;
        end
        checkOutput("rst_mid_no_done", 64'(done_seen), 64'd0);

        $display("[TB] randomized frames");
        for (int i = 0; i < 12; i++) begin
            rtx  = $urandom;
            rstx = $urandom;
            applyStimulus(2'($urandom), $urandom_range(0, 40), $urandom_range(0, 3),
                          rtx, rstx, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
